// File: rtl/pulse_barrier.sv
// Pulse barrier: collects one arrival per enabled channel, then issues fire,
// followed GAP cycles later by done; an optional timeout abandons a partial set.
module pulse_barrier #(
  parameter int N_CH  = 4,
  parameter int GAP   = 1,
  parameter int TO_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in,
  input  logic [N_CH-1:0]   en_mask,
  input  logic [TO_W-1:0]   timeout_val,
  input  logic              err_clr,
  output logic              fire,
  output logic              done,
  output logic              timeout,
  output logic [N_CH-1:0]   seen,
  output logic [N_CH-1:0]   dup_err,
  output logic [CNT_W-1:0]  fire_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FIRE    = 2'd1,
    WAIT    = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [7:0]       wait_cnt, wait_next;
  logic [TO_W-1:0]  to_cnt, to_next;
  logic [N_CH-1:0]  seen_next, dup_next, active;
  logic [CNT_W-1:0] cnt_next;
  logic             complete, timeout_hit;
  logic             fire_next, done_next, timeout_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      wait_cnt <= '0;
      to_cnt   <= '0;
      seen     <= '0;
      dup_err  <= '0;
      fire_cnt <= '0;
      fire     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      to_cnt   <= to_next;
      seen     <= seen_next;
      dup_err  <= dup_next;
      fire_cnt <= cnt_next;
      fire     <= fire_next;
      done     <= done_next;
      timeout  <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state;
    wait_next    = wait_cnt;
    done_next    = 1'b0;
    active       = seen & en_mask;
    complete     = (state == COLLECT) && (en_mask != '0) && (active == en_mask);
    timeout_hit  = (state == COLLECT) && (timeout_val != '0) && !complete &&
                   (to_cnt == (timeout_val - TO_W'(1)));
    fire_next    = complete;
    timeout_next = timeout_hit;
    cnt_next     = complete ? fire_cnt + CNT_W'(1) : fire_cnt;
    // Arrivals during FIRE/WAIT accumulate so nothing is lost across a release.
    seen_next    = ((complete || timeout_hit) ? '0 : seen) | (in & en_mask);
    dup_next     = (err_clr ? '0 : dup_err) |
                   (in & en_mask & seen & {N_CH{!complete}});
    to_next      = ((state == COLLECT) && (active != '0) && !complete && !timeout_hit)
                   ? to_cnt + TO_W'(1) : '0;

    case (state)
      COLLECT: begin
        if (complete) state_next = FIRE;
      end
      FIRE: begin
        if (GAP == 1) begin
          state_next = COLLECT;
          done_next  = 1'b1;
        end else begin
          state_next = WAIT;
          wait_next  = '0;
        end
      end
      WAIT: begin
        // done rises together with the return to COLLECT, GAP cycles after fire.
        if (wait_cnt == 8'(GAP - 2)) begin
          state_next = COLLECT;
          done_next  = 1'b1;
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  assign busy = (state != COLLECT);

endmodule

// File: tb/tb_pulse_barrier.sv
// Directed bench for pulse_barrier: one GAP=1 instance (a) and one GAP=3
// instance (b) share stimulus; each scenario starts from reset.
module tb_pulse_barrier;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in;
  logic [3:0]  en_mask;
  logic [15:0] timeout_val;
  logic        err_clr;

  logic       fire_a, done_a, timeout_a, busy_a;
  logic [3:0] seen_a, dup_a;
  logic [7:0] cnt_a;
  logic       fire_b, done_b, timeout_b, busy_b;
  logic [3:0] seen_b, dup_b;
  logic [7:0] cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_barrier #(.N_CH(4), .GAP(1), .TO_W(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in(in), .en_mask(en_mask), .timeout_val(timeout_val),
    .err_clr(err_clr), .fire(fire_a), .done(done_a), .timeout(timeout_a),
    .seen(seen_a), .dup_err(dup_a), .fire_cnt(cnt_a), .busy(busy_a)
  );

  pulse_barrier #(.N_CH(4), .GAP(3), .TO_W(16), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in(in), .en_mask(en_mask), .timeout_val(timeout_val),
    .err_clr(err_clr), .fire(fire_b), .done(done_b), .timeout(timeout_b),
    .seen(seen_b), .dup_err(dup_b), .fire_cnt(cnt_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the start of cycle 0 with reset released.
  task automatic do_reset(input logic [3:0] mask, input logic [15:0] tv);
    rst = 1'b1; in = '0; err_clr = 1'b0; en_mask = mask; timeout_val = tv;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in = '0; en_mask = 4'hF; timeout_val = '0; err_clr = 1'b0;
    tick();
    check("rst_fire",    32'(fire_a),    0);
    check("rst_done",    32'(done_a),    0);
    check("rst_timeout", 32'(timeout_a), 0);
    check("rst_busy",    32'(busy_a),    0);
    check("rst_seen",    32'(seen_a),    0);
    check("rst_dup",     32'(dup_a),     0);
    check("rst_cnt",     32'(cnt_a),     0);

    // Staggered arrivals, GAP=1.
    do_reset(4'hF, 16'd0);
    in = 4'h1; tick();
    in = 4'h2; tick();
    in = 4'h4; tick();
    in = 4'h8; tick();
    in = 4'h0;
    check("stag_c4_seen", 32'(seen_a), 32'hF);
    check("stag_c4_fire", 32'(fire_a), 0);
    tick();
    check("stag_c5_fire", 32'(fire_a), 1);
    check("stag_c5_cnt",  32'(cnt_a),  1);
    check("stag_c5_busy", 32'(busy_a), 1);
    check("stag_c5_done", 32'(done_a), 0);
    tick();
    check("stag_c6_done", 32'(done_a), 1);
    check("stag_c6_fire", 32'(fire_a), 0);
    check("stag_c6_seen", 32'(seen_a), 0);
    check("stag_c6_busy", 32'(busy_a), 0);
    tick();
    check("stag_c7_done", 32'(done_a), 0);

    // Simultaneous arrivals, GAP=3, with an arrival during WAIT.
    do_reset(4'hF, 16'd0);
    in = 4'hF; tick();
    in = 4'h0;
    check("gap3_c1_seen", 32'(seen_b), 32'hF);
    check("gap3_c1_busy", 32'(busy_b), 0);
    tick();
    check("gap3_c2_fire", 32'(fire_b), 1);
    check("gap3_c2_busy", 32'(busy_b), 1);
    tick();
    in = 4'h1;
    check("gap3_c3_busy", 32'(busy_b), 1);
    check("gap3_c3_fire", 32'(fire_b), 0);
    tick();
    in = 4'h0;
    check("gap3_c4_busy", 32'(busy_b), 1);
    check("gap3_c4_done", 32'(done_b), 0);
    check("gap3_c4_seen", 32'(seen_b), 32'h1);
    tick();
    check("gap3_c5_done", 32'(done_b), 1);
    check("gap3_c5_busy", 32'(busy_b), 0);
    tick();
    check("gap3_c6_seen", 32'(seen_b), 32'h1);
    check("gap3_c6_done", 32'(done_b), 0);
    check("gap3_c6_fire", 32'(fire_b), 0);
    check("gap3_c6_cnt",  32'(cnt_b),  1);

    // Partial mask: ch1/ch3 are ignored.
    do_reset(4'b0101, 16'd0);
    in = 4'b1010; tick();
    check("mask_c1_seen", 32'(seen_a), 0);
    in = 4'b0101; tick();
    in = 4'b0000;
    check("mask_c2_seen", 32'(seen_a), 32'h5);
    tick();
    check("mask_c3_fire", 32'(fire_a), 1);
    check("mask_c3_cnt",  32'(cnt_a),  1);

    // Empty mask never fires.
    do_reset(4'h0, 16'd0);
    in = 4'hF; tick(); tick();
    in = 4'h0; tick();
    check("nomask_fire", 32'(fire_a), 0);
    check("nomask_seen", 32'(seen_a), 0);

    // Timeout after 5 cycles of a partial set.
    do_reset(4'hF, 16'd5);
    in = 4'h1; tick();
    in = 4'h0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("to_c%0d_timeout", c), 32'(timeout_a), 0);
      tick();
    end
    check("to_c6_timeout", 32'(timeout_a), 1);
    check("to_c6_seen",    32'(seen_a),    0);
    check("to_c6_fire",    32'(fire_a),    0);
    check("to_c6_cnt",     32'(cnt_a),     0);
    tick();
    check("to_c7_timeout", 32'(timeout_a), 0);

    // Duplicate arrival on ch1 with ch3 missing.
    do_reset(4'hF, 16'd0);
    in = 4'h2; tick();
    in = 4'h0; tick();
    in = 4'h2; tick();
    in = 4'h0;
    check("dup_c3_err",  32'(dup_a),  32'h2);
    check("dup_c3_seen", 32'(seen_a), 32'h2);
    tick();
    check("dup_c4_sticky", 32'(dup_a), 32'h2);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    check("dup_c5_clr", 32'(dup_a), 0);

    // Reset asserted during the fire cycle aborts the sequence.
    do_reset(4'hF, 16'd0);
    in = 4'hF; tick();
    in = 4'h0; tick();
    check("rfire_a_fire", 32'(fire_a), 1);
    check("rfire_b_fire", 32'(fire_b), 1);
    rst = 1'b1;
    #1;
    check("rfire_fire_now", 32'(fire_a), 0);
    check("rfire_busy_now", 32'(busy_b), 0);
    check("rfire_cnt_now",  32'(cnt_a),  0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rfire_a_nodone%0d", c), 32'(done_a), 0);
      check($sformatf("rfire_b_nodone%0d", c), 32'(done_b), 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
